// File: rtl/rpn_op_sequencer.sv
// Command sequencer for the RPN calculator stack: turns PUSH/ADD/SUB/DROP
// into pop/push strobe handshakes, does the arithmetic and reports status.
module rpn_op_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  cmd_ready,
    output logic                  done,
    output logic [1:0]            err,
    output logic                  carry,
    output logic [DATA_WIDTH-1:0] disp_value,
    output logic [DATA_WIDTH-1:0] stk_din,
    output logic                  stk_push,
    output logic                  stk_pop,
    input  logic [DATA_WIDTH-1:0] stk_dout,
    input  logic                  stk_pushed,
    input  logic                  stk_poped,
    input  logic                  stk_full,
    input  logic                  stk_empty
);
    typedef enum logic [3:0] {
        IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, CALC,
        REQ_R, WAIT_R, RESTORE, WAIT_RS, FIN
    } state_t;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_DROP = 2'd3;

    localparam logic [1:0] E_OK    = 2'd0;
    localparam logic [1:0] E_UNDER = 2'd1;
    localparam logic [1:0] E_OVER  = 2'd2;
    localparam logic [1:0] E_TMO   = 2'd3;

    // Last WAIT_* count before giving up; the done pulse then lands
    // ACK_TIMEOUT cycles after the strobe.
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 2);

    state_t                state;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] a, b, r;
    logic [7:0]            tmo;
    logic [DATA_WIDTH:0]   sum;
    logic                  tmo_hit;

    // B is second-from-top, A is top; bit DATA_WIDTH is carry or borrow.
    always_comb begin
        sum = (op == OP_SUB) ? ({1'b0, b} - {1'b0, a}) : ({1'b0, b} + {1'b0, a});
        tmo_hit = (tmo == TMO_LAST);
    end

    // Strobes are registered on entry to a REQ_* state, so the REQ_* state
    // itself only inspects whether its strobe actually went out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            done       <= 1'b0;
            err        <= E_OK;
            carry      <= 1'b0;
            disp_value <= '0;
            stk_din    <= '0;
            stk_push   <= 1'b0;
            stk_pop    <= 1'b0;
            op         <= OP_PUSH;
            a          <= '0;
            b          <= '0;
            r          <= '0;
            tmo        <= '0;
        end else begin
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    cmd_ready <= 1'b0;
                    op        <= cmd_op;
                    carry     <= 1'b0;
                    tmo       <= '0;
                    if (cmd_op == OP_PUSH) begin
                        r        <= cmd_data;
                        stk_din  <= cmd_data;
                        stk_push <= !stk_full;
                        state    <= REQ_R;
                    end else begin
                        stk_pop <= !stk_empty;
                        state   <= REQ_A;
                    end
                end
                REQ_A: begin
                    if (stk_pop) state <= WAIT_A;
                    else begin
                        done  <= 1'b1;
                        err   <= E_UNDER;
                        state <= FIN;
                    end
                end
                WAIT_A: begin
                    if (stk_poped) begin
                        a   <= stk_dout;
                        tmo <= '0;
                        if (op == OP_DROP) begin
                            done  <= 1'b1;
                            err   <= E_OK;
                            state <= FIN;
                        end else begin
                            stk_pop <= !stk_empty;
                            state   <= REQ_B;
                        end
                    end else if (tmo_hit) begin
                        done  <= 1'b1;
                        err   <= E_TMO;
                        state <= FIN;
                    end else tmo <= tmo + 8'd1;
                end
                REQ_B: state <= stk_pop ? WAIT_B : RESTORE;
                WAIT_B: begin
                    if (stk_poped) begin
                        b     <= stk_dout;
                        state <= CALC;
                    end else if (tmo_hit) begin
                        done  <= 1'b1;
                        err   <= E_TMO;
                        state <= FIN;
                    end else tmo <= tmo + 8'd1;
                end
                CALC: begin
                    r        <= sum[DATA_WIDTH-1:0];
                    carry    <= sum[DATA_WIDTH];
                    stk_din  <= sum[DATA_WIDTH-1:0];
                    stk_push <= !stk_full;
                    tmo      <= '0;
                    state    <= REQ_R;
                end
                REQ_R: begin
                    if (stk_push) state <= WAIT_R;
                    else begin
                        done  <= 1'b1;
                        err   <= E_OVER;
                        state <= FIN;
                    end
                end
                WAIT_R: begin
                    if (stk_pushed) begin
                        disp_value <= r;
                        done       <= 1'b1;
                        err        <= E_OK;
                        state      <= FIN;
                    end else if (tmo_hit) begin
                        done  <= 1'b1;
                        err   <= E_TMO;
                        state <= FIN;
                    end else tmo <= tmo + 8'd1;
                end
                RESTORE: begin
                    stk_din  <= a;
                    stk_push <= 1'b1;
                    tmo      <= '0;
                    state    <= WAIT_RS;
                end
                WAIT_RS: begin
                    if (stk_pushed) begin
                        done  <= 1'b1;
                        err   <= E_UNDER;
                        state <= FIN;
                    end else if (tmo_hit) begin
                        done  <= 1'b1;
                        err   <= E_TMO;
                        state <= FIN;
                    end else tmo <= tmo + 8'd1;
                end
                FIN: begin
                    done      <= 1'b0;
                    err       <= E_OK;
                    carry     <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rpn_op_sequencer.sv
// Bench for rpn_op_sequencer: behavioural stack model plus a queue-based
// reference of the RPN command rules, directed cases then random commands.
module tb_rpn_op_sequencer;
    localparam int T     = 15;
    localparam int DEPTH = 4;

    logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_ready, done, carry, stk_push, stk_pop;
    logic [1:0] err;
    logic [7:0] disp_value, stk_din;
    logic [7:0] stk_dout = 8'd0;
    logic       stk_pushed = 1'b0, stk_poped = 1'b0, stk_full = 1'b0, stk_empty = 1'b1;

    int tests = 0, fails = 0;
    logic [7:0] stk_q[$];
    int cyc = 0, pop_cyc = 0, both_cnt = 0, pop_seen = 0, push_seen = 0;
    bit hold_pop = 1'b0, force_full = 1'b0;
    int clr_tok = 0, clr_seen = 0, late_tok = 0, late_seen = 0;
    logic [7:0] tmp;

    int ref_q[$];
    int ref_disp = 0;

    rpn_op_sequencer #(.DATA_WIDTH(8), .ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .done(done), .err(err), .carry(carry), .disp_value(disp_value),
        .stk_din(stk_din), .stk_push(stk_push), .stk_pop(stk_pop), .stk_dout(stk_dout),
        .stk_pushed(stk_pushed), .stk_poped(stk_poped), .stk_full(stk_full), .stk_empty(stk_empty)
    );

    always #5 clk = ~clk;

    // Stack controller model: acknowledges one cycle after each strobe.
    always @(posedge clk) begin
        stk_poped  <= 1'b0;
        stk_pushed <= 1'b0;
        if (stk_pop && stk_push) both_cnt++;
        if (stk_pop) begin
            pop_seen++;
            pop_cyc = cyc;
            if (!hold_pop) begin
                tmp = (stk_q.size() > 0) ? stk_q[stk_q.size()-1] : 8'h00;
                if (stk_q.size() > 0) stk_q.delete(stk_q.size()-1);
                stk_dout  <= tmp;
                stk_poped <= 1'b1;
            end
        end
        if (stk_push) begin
            push_seen++;
            if (stk_q.size() < DEPTH) stk_q.push_back(stk_din);
            stk_pushed <= 1'b1;
        end
        if (clr_tok != clr_seen) begin
            clr_seen = clr_tok;
            stk_q.delete();
        end
        if (late_tok != late_seen) begin
            late_seen = late_tok;
            stk_dout  <= 8'hAA;
            stk_poped <= 1'b1;
        end
        stk_empty <= (stk_q.size() == 0);
        stk_full  <= force_full || (stk_q.size() >= DEPTH);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stack();
        clr_tok++;
        ref_q.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input bit poke,
                          output int lat, output int tdone, output logic [1:0] e,
                          output logic c, output int np, output int nq);
        int t0, p0, q0;
        bit got;
        @(negedge clk);
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        t0 = cyc; p0 = pop_seen; q0 = push_seen;
        @(negedge clk);
        if (poke) begin
            cmd_op = 2'd0; cmd_data = 8'h77;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        got = 1'b0; lat = -1; tdone = -1; e = 2'd0; c = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (done) begin
                got = 1'b1; lat = cyc - t0; tdone = cyc; e = err; c = carry;
            end else @(negedge clk);
        end
        np = pop_seen - p0;
        nq = push_seen - q0;
        chk("done_seen", 32'(got), 32'd1);
    endtask

    task automatic exp_cmd(input string tag, input logic [1:0] op, input logic [7:0] d,
                           input bit poke, input int x_lat, input logic [1:0] x_e,
                           input logic x_c, input int x_np, input int x_nq, output int tdone);
        int lat, np, nq;
        logic [1:0] e;
        logic c;
        do_cmd(op, d, poke, lat, tdone, e, c, np, nq);
        chk({tag, "_lat"}, lat, x_lat);
        chk({tag, "_err"}, 32'(e), 32'(x_e));
        chk({tag, "_carry"}, 32'(c), 32'(x_c));
        chk({tag, "_pops"}, np, x_np);
        chk({tag, "_pushes"}, nq, x_nq);
    endtask

    // Reference: the RPN rules on a plain queue, with the nominal latencies.
    task automatic ref_cmd(input logic [1:0] op, input logic [7:0] d, output int lat,
                           output logic [1:0] e, output logic c, output int np, output int nq);
        int a, b, s;
        e = 2'd0; c = 1'b0; np = 0; nq = 0; lat = 0;
        if (op == 2'd0) begin
            if (ref_q.size() >= DEPTH) begin e = 2'd2; lat = 2; end
            else begin ref_q.push_back(int'(d)); ref_disp = int'(d); lat = 3; nq = 1; end
        end else if (ref_q.size() == 0) begin
            e = 2'd1; lat = 2;
        end else if (op == 2'd3) begin
            ref_q.delete(ref_q.size()-1); lat = 3; np = 1;
        end else if (ref_q.size() == 1) begin
            e = 2'd1; lat = 7; np = 1; nq = 1;
        end else begin
            a = ref_q[ref_q.size()-1];
            b = ref_q[ref_q.size()-2];
            ref_q.delete(ref_q.size()-1);
            ref_q.delete(ref_q.size()-1);
            s = (op == 2'd1) ? b + a : b - a;
            c = (op == 2'd1) ? (s > 255) : (a > b);
            s = ((s % 256) + 256) % 256;
            ref_q.push_back(s);
            ref_disp = s;
            lat = 8; np = 2; nq = 1;
        end
    endtask

    initial begin
        int td, lat, np, nq, any_done, p0, q0;
        logic [1:0] e, op;
        logic c;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_carry", 32'(carry), 0);
        chk("rst_disp", 32'(disp_value), 0);
        chk("rst_din", 32'(stk_din), 0);
        chk("rst_strobes", 32'({stk_push, stk_pop}), 0);
        rst = 1'b0;

        exp_cmd("push5", 2'd0, 8'h05, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        chk("ready_at_done", 32'(cmd_ready), 0);
        @(negedge clk);
        chk("ready_after_done", 32'(cmd_ready), 1);
        exp_cmd("push3", 2'd0, 8'h03, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        exp_cmd("add8", 2'd1, 8'h00, 1'b0, 8, 2'd0, 1'b0, 2, 1, td);
        chk("add8_disp", 32'(disp_value), 32'h08);
        chk("add8_depth", stk_q.size(), 1);
        if (stk_q.size() == 1) chk("add8_top", 32'(stk_q[0]), 32'h08);

        clear_stack();
        exp_cmd("p03", 2'd0, 8'h03, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        exp_cmd("p05", 2'd0, 8'h05, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        exp_cmd("subfe", 2'd2, 8'h00, 1'b0, 8, 2'd0, 1'b1, 2, 1, td);
        chk("subfe_disp", 32'(disp_value), 32'hFE);

        clear_stack();
        exp_cmd("pf0", 2'd0, 8'hF0, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        exp_cmd("p20", 2'd0, 8'h20, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        exp_cmd("addc", 2'd1, 8'h00, 1'b0, 8, 2'd0, 1'b1, 2, 1, td);
        chk("addc_disp", 32'(disp_value), 32'h10);
        clear_stack();
        exp_cmd("p10a", 2'd0, 8'h10, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        exp_cmd("p10b", 2'd0, 8'h10, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        exp_cmd("sub0", 2'd2, 8'h00, 1'b0, 8, 2'd0, 1'b0, 2, 1, td);
        chk("sub0_disp", 32'(disp_value), 32'h00);

        clear_stack();
        exp_cmd("p07", 2'd0, 8'h07, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        exp_cmd("p09", 2'd0, 8'h09, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        exp_cmd("drop9", 2'd3, 8'h00, 1'b0, 3, 2'd0, 1'b0, 1, 0, td);
        exp_cmd("restore", 2'd1, 8'h00, 1'b0, 7, 2'd1, 1'b0, 1, 1, td);
        chk("restore_depth", stk_q.size(), 1);
        if (stk_q.size() == 1) chk("restore_top", 32'(stk_q[0]), 32'h07);
        chk("restore_disp", 32'(disp_value), 32'h09);

        force_full = 1'b1;
        exp_cmd("ovf", 2'd0, 8'h09, 1'b0, 2, 2'd2, 1'b0, 0, 0, td);
        chk("ovf_disp", 32'(disp_value), 32'h09);
        force_full = 1'b0;

        clear_stack();
        exp_cmd("drop_empty", 2'd3, 8'h00, 1'b0, 2, 2'd1, 1'b0, 0, 0, td);
        exp_cmd("p04", 2'd0, 8'h04, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        exp_cmd("busy_poke", 2'd3, 8'h00, 1'b1, 3, 2'd0, 1'b0, 1, 0, td);
        chk("busy_poke_depth", stk_q.size(), 0);

        exp_cmd("p06", 2'd0, 8'h06, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        hold_pop = 1'b1;
        exp_cmd("tmo", 2'd3, 8'h00, 1'b0, T + 1, 2'd3, 1'b0, 1, 0, td);
        chk("tmo_gap", td - pop_cyc, T);
        hold_pop = 1'b0;
        late_tok++;
        any_done = 0; p0 = pop_seen; q0 = push_seen;
        repeat (5) begin
            @(negedge clk);
            if (done) any_done++;
        end
        chk("late_ack_done", any_done, 0);
        chk("late_ack_ready", 32'(cmd_ready), 1);
        chk("late_ack_strobes", (pop_seen - p0) + (push_seen - q0), 0);
        chk("late_ack_disp", 32'(disp_value), 32'h06);

        clear_stack();
        exp_cmd("p01", 2'd0, 8'h01, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        exp_cmd("p02", 2'd0, 8'h02, 1'b0, 3, 2'd0, 1'b0, 0, 1, td);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pre_rst_pop", 32'(stk_pop), 1);
        chk("pre_rst_ready", 32'(cmd_ready), 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(cmd_ready), 1);
        chk("mid_rst_strobes", 32'({stk_push, stk_pop}), 0);
        chk("mid_rst_disp", 32'(disp_value), 0);
        @(negedge clk);
        rst = 1'b0;
        clear_stack();
        ref_disp = 0;

        for (int n = 0; n < 70; n++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) op = 2'd0;
            d = 8'($urandom);
            ref_cmd(op, d, lat, e, c, np, nq);
            exp_cmd("rnd", op, d, 1'b0, lat, e, c, np, nq, td);
            chk("rnd_disp", 32'(disp_value), ref_disp);
            chk("rnd_depth", stk_q.size(), ref_q.size());
            if (ref_q.size() > 0 && stk_q.size() > 0)
                chk("rnd_top", 32'(stk_q[stk_q.size()-1]), ref_q[ref_q.size()-1]);
        end

        chk("both_strobes", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
